// File: rtl/scrub_pkg.sv
// rtl/scrub_pkg.sv - shared types, constants and address helper for the ECC scrubber
package scrub_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_REQ,
        ST_READ,
        ST_WRITE,
        ST_NEXT,
        ST_HALT
    } scrub_state_e;

    localparam int CNT_W_DEF = 16;

    // Data the memory presents when its decoder reports a double-bit error
    localparam logic [31:0] POISON_WORD = 32'hBAAD_FEED;

    // Word index to byte address on the 32-bit data port
    function automatic logic [31:0] word_to_byte(input logic [29:0] word);
        return {word, 2'b00};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter, cleared only by reset
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Count up on inc_i, sticking at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ecc_scrubber.sv
// rtl/ecc_scrubber.sv - background ECC memory scrubber; SCRUB_DERR_HALT_EN stops on double-bit errors
module ecc_scrubber
    import scrub_pkg::*;
#(
    parameter int DEPTH    = 1024,
    parameter int INTERVAL = 256,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             scrub_req,
    input  logic             scrub_gnt,
    output logic [31:0]      mem_A,
    output logic             mem_WE,
    output logic [31:0]      mem_WD,
    input  logic [31:0]      mem_RD,
    input  logic             mem_s_err,
    input  logic             mem_d_err,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt,
    output logic [31:0]      last_err_addr,
    output logic             pass_done,
    output logic             halted
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IVL_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [IVL_W-1:0] IVL_LOAD = IVL_W'(INTERVAL - 1);

`ifdef SCRUB_DERR_HALT_EN
    localparam scrub_state_e DERR_NEXT = ST_HALT;
`else
    localparam scrub_state_e DERR_NEXT = ST_NEXT;
`endif

    scrub_state_e     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IVL_W-1:0] ivl_q, ivl_d;
    logic [31:0]      wd_q, wd_d;
    logic [31:0]      last_q, last_d;
    logic [31:0]      cur_addr;
    logic             read_ok;
    logic             read_s_err;
    logic             read_d_err;

    assign cur_addr   = word_to_byte(30'(idx_q));
    // A read only counts on a cycle the arbiter actually routes us to memory
    assign read_ok    = (state_q == ST_READ) && scrub_gnt;
    // Both flags together are treated as uncorrectable
    assign read_d_err = read_ok && mem_d_err;
    assign read_s_err = read_ok && mem_s_err && !mem_d_err;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (en) state_d = ST_WAIT;
            ST_WAIT: begin
                if (!en)               state_d = ST_IDLE;
                else if (ivl_q == '0)  state_d = ST_REQ;
            end
            ST_REQ: begin
                if (!en)               state_d = ST_IDLE;
                else if (scrub_gnt)    state_d = ST_READ;
            end
            ST_READ: begin
                if (!scrub_gnt)        state_d = ST_REQ;
                else if (mem_d_err)    state_d = DERR_NEXT;
                else if (mem_s_err)    state_d = ST_WRITE;
                else                   state_d = ST_NEXT;
            end
            ST_WRITE: state_d = ST_NEXT;
            ST_NEXT:  state_d = en ? ST_WAIT : ST_IDLE;
            ST_HALT:  if (!en) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Port outputs decoded from the state and word index registers
    always_comb begin
        scrub_req = 1'b0;
        mem_WE    = 1'b0;
        mem_A     = '0;
        pass_done = 1'b0;
        halted    = 1'b0;
        case (state_q)
            ST_REQ, ST_READ: begin
                scrub_req = 1'b1;
                mem_A     = cur_addr;
            end
            ST_WRITE: begin
                scrub_req = 1'b1;
                mem_WE    = 1'b1;
                mem_A     = cur_addr;
            end
            ST_NEXT:  pass_done = (idx_q == LAST_IDX);
            ST_HALT: begin
`ifdef SCRUB_DERR_HALT_EN
                halted = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    // Interval timer, word walk, write-back data and error address capture
    always_comb begin
        idx_d  = idx_q;
        ivl_d  = ivl_q;
        wd_d   = wd_q;
        last_d = last_q;
        if ((state_q == ST_IDLE) || (state_q == ST_NEXT)) begin
            ivl_d = IVL_LOAD;
        end else if ((state_q == ST_WAIT) && (ivl_q != '0)) begin
            ivl_d = ivl_q - IVL_W'(1);
        end
        if (read_s_err) begin
            wd_d = mem_RD;
        end
        if (read_d_err) begin
            last_d = cur_addr;
        end
        if (state_q == ST_NEXT) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            ivl_q  <= '0;
            wd_q   <= '0;
            last_q <= '0;
        end else begin
            idx_q  <= idx_d;
            ivl_q  <= ivl_d;
            wd_q   <= wd_d;
            last_q <= last_d;
        end
    end

    assign mem_WD        = wd_q;
    assign last_err_addr = last_q;

    sat_counter #(.W(CNT_W)) u_corr_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (read_s_err),
        .cnt_o (corr_cnt)
    );

    sat_counter #(.W(CNT_W)) u_uncorr_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (read_d_err),
        .cnt_o (uncorr_cnt)
    );

endmodule

// File: tb/tb_ecc_scrubber.sv
// tb/tb_ecc_scrubber.sv - randomized bench for ecc_scrubber against a procedural scrub model
module tb_ecc_scrubber;
    import scrub_pkg::*;

    localparam int DEPTH    = 8;
    localparam int INTERVAL = 4;
    localparam int CNT_W    = 3;
    localparam int PASS_CYC = DEPTH * (INTERVAL + 3);
    localparam int MAXC     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             scrub_gnt = 1'b0;
    logic             scrub_req, mem_WE, pass_done, halted;
    logic [31:0]      mem_A, mem_WD, mem_RD, last_err_addr;
    logic             mem_s_err, mem_d_err;
    logic [CNT_W-1:0] corr_cnt, uncorr_cnt;

    int checks = 0;
    int failures = 0;

    ecc_scrubber #(.DEPTH(DEPTH), .INTERVAL(INTERVAL), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en),
        .scrub_req(scrub_req), .scrub_gnt(scrub_gnt),
        .mem_A(mem_A), .mem_WE(mem_WE), .mem_WD(mem_WD), .mem_RD(mem_RD),
        .mem_s_err(mem_s_err), .mem_d_err(mem_d_err),
        .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt),
        .last_err_addr(last_err_addr), .pass_done(pass_done), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- memory: data is stored clean, errors tracked per word
    // mem_err: 0 clean, 1 single-bit, 2 double (d flag only), 3 double (both flags)
    logic [31:0] mem_data [DEPTH];
    int          mem_err  [DEPTH];
    logic        junk_s = 1'b0, junk_d = 1'b0;
    logic [2:0]  a_idx;
    int          wr_count = 0;
    logic [31:0] wr_last_a = '0, wr_last_d = '0;

    assign a_idx = mem_A[4:2];

    always_comb begin
        if (scrub_gnt) begin
            mem_RD    = (mem_err[a_idx] >= 2) ? POISON_WORD : mem_data[a_idx];
            mem_s_err = (mem_err[a_idx] == 1) || (mem_err[a_idx] == 3);
            mem_d_err = (mem_err[a_idx] >= 2);
        end else begin
            mem_RD    = 32'h0BAD_0BAD;
            mem_s_err = junk_s;
            mem_d_err = junk_d;
        end
    end

    always @(posedge clk) begin
        if (!rst && mem_WE && scrub_gnt) begin
            mem_data[a_idx] = mem_WD;
            mem_err[a_idx]  = 0;
            wr_count++;
            wr_last_a = mem_A;
            wr_last_d = mem_WD;
        end
    end

    // ---------------- reference model: walks words procedurally, one clock per tick
    logic        exp_req, exp_we, exp_pd, exp_halt;
    logic [31:0] exp_a, exp_wd, m_last;
    int          m_idx, m_corr, m_uncorr;
    bit          m_abort;
    logic        s_en, s_gnt, s_s, s_d, s_rst;
    logic [31:0] s_rd;

    function automatic int sat_inc(input int v);
        return (v < MAXC) ? v + 1 : MAXC;
    endfunction

    task automatic tick();
        @(posedge clk);
        s_en = en; s_gnt = scrub_gnt; s_s = mem_s_err; s_d = mem_d_err;
        s_rd = mem_RD; s_rst = rst;
        if (rst) m_abort = 1;
    endtask

    task automatic set_exp(input logic req, input logic we, input logic pd, input logic hlt);
        exp_req = req; exp_we = we; exp_pd = pd; exp_halt = hlt;
        exp_a = 32'(m_idx * 4);
    endtask

    task automatic m_reset();
        m_idx = 0; m_corr = 0; m_uncorr = 0; m_last = '0; exp_wd = '0; m_abort = 0;
        set_exp(0, 0, 0, 0);
    endtask

    task automatic model_run();
        forever begin
            set_exp(0, 0, 0, 0);
            for (int k = 0; k < INTERVAL; k++) begin
                tick();
                if (m_abort || !s_en) return;
            end
            forever begin
                set_exp(1, 0, 0, 0);
                tick();
                if (m_abort || !s_en) return;
                if (s_gnt) begin
                    tick();
                    if (m_abort) return;
                    if (s_gnt) break;
                end
            end
            if (s_d) begin
                m_uncorr = sat_inc(m_uncorr);
                m_last   = 32'(m_idx * 4);
`ifdef SCRUB_DERR_HALT_EN
                set_exp(0, 0, 0, 1);
                do begin
                    tick();
                    if (m_abort) return;
                end while (s_en);
                return;
`endif
            end else if (s_s) begin
                m_corr = sat_inc(m_corr);
                exp_wd = s_rd;
                set_exp(1, 1, 0, 0);
                tick();
                if (m_abort) return;
            end
            set_exp(0, 0, m_idx == DEPTH - 1, 0);
            tick();
            if (m_abort) return;
            m_idx = (m_idx + 1) % DEPTH;
            if (!s_en) return;
        end
    endtask

    initial begin
        m_reset();
        forever begin
            set_exp(0, 0, 0, 0);
            do begin
                tick();
                if (m_abort) m_reset();
            end while (!(s_en && !s_rst));
            model_run();
            if (m_abort) m_reset();
        end
    end

    // ---------------- per-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("scrub_req", 32'(scrub_req), 32'(exp_req));
            chk("mem_WE", 32'(mem_WE), 32'(exp_we));
            if (exp_req) chk("mem_A", mem_A, exp_a);
            if (exp_we) chk("mem_WD", mem_WD, exp_wd);
            chk("pass_done", 32'(pass_done), 32'(exp_pd));
            chk("halted", 32'(halted), 32'(exp_halt));
            chk("corr_cnt", 32'(corr_cnt), 32'(m_corr));
            chk("uncorr_cnt", 32'(uncorr_cnt), 32'(m_uncorr));
            chk("last_err_addr", last_err_addr, m_last);
        end
    end

    // ---------------- pass_done spacing monitor
    int cyc = 0, pd_count = 0, pd_prev = 0, pd_gap = 0;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (!rst && pass_done) begin
            if (pd_count > 0) pd_gap = cyc - pd_prev;
            pd_prev = cyc;
            pd_count++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus
    initial begin
        int pd0;
        bit seen;
        for (int i = 0; i < DEPTH; i++) begin
            mem_data[i] = 32'hA500_0000 + 32'(i * 32'h0001_0203);
            mem_err[i]  = 0;
        end
        mem_data[3] = 32'h1234_5678;

        // reset values
        cycles(3);
        chk("rst scrub_req", 32'(scrub_req), 0);
        chk("rst mem_WE", 32'(mem_WE), 0);
        chk("rst mem_A", mem_A, 0);
        chk("rst mem_WD", mem_WD, 0);
        chk("rst corr_cnt", 32'(corr_cnt), 0);
        chk("rst uncorr_cnt", 32'(uncorr_cnt), 0);
        chk("rst last_err_addr", last_err_addr, 0);
        chk("rst pass_done", 32'(pass_done), 0);
        chk("rst halted", 32'(halted), 0);
        rst = 1'b0;

        // clean memory, grant tied high
        en = 1'b1; scrub_gnt = 1'b1; pd_count = 0;
        cycles(3 * PASS_CYC + 10);
        chk("clean pass count", 32'(pd_count), 3);
        chk("clean pass gap", 32'(pd_gap), 56);
        chk("clean no writes", 32'(wr_count), 0);

        // single-bit error in word 3
        mem_err[3] = 1;
        cycles(2 * PASS_CYC);
        chk("sbe write count", 32'(wr_count), 1);
        chk("sbe write addr", wr_last_a, 32'h0000_000C);
        chk("sbe write data", wr_last_d, 32'h1234_5678);
        chk("sbe rewritten clean", 32'(mem_err[3]), 0);
        chk("sbe corr_cnt", 32'(corr_cnt), 1);

        // double-bit error in word 6
        mem_err[6] = 2;
        for (int k = 0; k < 2 * PASS_CYC && uncorr_cnt == 0; k++) cycles(1);
        mem_err[6] = 0;
        chk("dbe uncorr_cnt", 32'(uncorr_cnt), 1);
        chk("dbe last_err_addr", last_err_addr, 32'h0000_0018);
        chk("dbe no write", 32'(wr_count), 1);
`ifdef SCRUB_DERR_HALT_EN
        chk("dbe halted", 32'(halted), 1);
        cycles(20);
        chk("dbe still halted", 32'(halted), 1);
        chk("dbe req low", 32'(scrub_req), 0);
        en = 1'b0;
        cycles(2);
        en = 1'b1;
`else
        // both flags set on word 1 behaves as a double-bit error
        mem_err[1] = 3;
        for (int k = 0; k < 2 * PASS_CYC && uncorr_cnt == 1; k++) cycles(1);
        mem_err[1] = 0;
        chk("dbe2 uncorr_cnt", 32'(uncorr_cnt), 2);
        chk("dbe2 last_err_addr", last_err_addr, 32'h0000_0004);
        chk("dbe2 no write", 32'(wr_count), 1);
        pd0 = pd_count;
        cycles(PASS_CYC + 2);
        chk("dbe scrub continues", 32'(pd_count > pd0), 1);
`endif

        // grant withheld in REQ, then dropped during READ
        scrub_gnt = 1'b0;
        for (int k = 0; k < 2 * PASS_CYC && !scrub_req; k++) cycles(1);
        chk("gnt req raised", 32'(scrub_req), 1);
        cycles(10);
        chk("gnt req held", 32'(scrub_req), 1);
        scrub_gnt = 1'b1;
        cycles(1);
        scrub_gnt = 1'b0;
        cycles(1);
        chk("gnt retry req", 32'(scrub_req), 1);
        cycles(2);
        scrub_gnt = 1'b1;
        cycles(10);

        // randomized traffic, enable drops and error injection
        for (int n = 0; n < 2500; n++) begin
            scrub_gnt = ($urandom_range(9) < 7);
            en        = ($urandom_range(39) != 0);
            junk_s    = $urandom_range(1) == 1;
            junk_d    = $urandom_range(1) == 1;
            if ($urandom_range(59) == 0) mem_err[$urandom_range(DEPTH - 1)] = int'($urandom_range(3));
            cycles(1);
        end

        // saturation of the corrected counter
        en = 1'b1; scrub_gnt = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem_err[i] = 1;
        cycles(2 * PASS_CYC);
        chk("corr saturated", 32'(corr_cnt), 32'h7);
`ifndef SCRUB_DERR_HALT_EN
        for (int i = 0; i < DEPTH; i++) mem_err[i] = 2;
        cycles(PASS_CYC + 10);
        chk("uncorr saturated", 32'(uncorr_cnt), 32'h7);
`endif

        // reset in the middle of a write-back
        en = 1'b0;
        cycles(3);
        for (int i = 0; i < DEPTH; i++) mem_err[i] = 1;
        en = 1'b1;
        seen = 0;
        for (int k = 0; k < 2 * PASS_CYC && !seen; k++) begin
            @(negedge clk);
            seen = mem_WE;
        end
        chk("write reached", 32'(seen), 1);
        #1 rst = 1'b1;
        #1;
        chk("rstw mem_WE", 32'(mem_WE), 0);
        chk("rstw scrub_req", 32'(scrub_req), 0);
        chk("rstw mem_A", mem_A, 0);
        chk("rstw mem_WD", mem_WD, 0);
        chk("rstw corr_cnt", 32'(corr_cnt), 0);
        chk("rstw uncorr_cnt", 32'(uncorr_cnt), 0);
        chk("rstw last_err_addr", last_err_addr, 0);
        chk("rstw pass_done", 32'(pass_done), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < INTERVAL + 10 && !scrub_req; k++) cycles(1);
        chk("restart req", 32'(scrub_req), 1);
        chk("restart word 0", mem_A, 32'h0000_0000);
        cycles(PASS_CYC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ecc_scrubber.md
# ecc_scrubber

Background memory scrubber that acts as a second initiator on the ECC-protected data memory port. It walks every word, reads it through the memory's Hamming decoder, writes corrected data back when a single-bit error is flagged (re-encoding fresh check bits), and logs uncorrectable double-bit errors. It sits beside the core and uses the port only when an external arbiter grants it, between CPU accesses.

## Interface
- DEPTH, 1024, number of 32-bit words scrubbed (word index 0..DEPTH-1)
- INTERVAL, 256, idle cycles between consecutive word accesses (>=1)
- CNT_W, 16, width of the error counters
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; asynchronous, active-high
- en  in  1  scrub enable level
- scrub_req  out  1  port request to arbiter
- scrub_gnt  in  1  arbiter grant; memory mux selects scrubber while high
- mem_A  out  32  byte address, {word_idx, 2'b00}, upper bits zero
- mem_WE  out  1  write enable to memory
- mem_WD  out  32  write data (corrected word)
- mem_RD  in  32  memory read data (combinational, already corrected)
- mem_s_err  in  1  single-bit error flag for current mem_A
- mem_d_err  in  1  double-bit error flag for current mem_A
- corr_cnt  out  CNT_W  corrected-error count, saturating
- uncorr_cnt  out  CNT_W  uncorrectable-error count, saturating
- last_err_addr  out  32  byte address of most recent d_err
- pass_done  out  1  one-cycle pulse when word DEPTH-1 completes
- halted  out  1  high in HALT state (macro-dependent)

## Operation
- States: IDLE, WAIT, REQ, READ, WRITE, NEXT, HALT.
- IDLE: outputs quiet; en=1 -> WAIT with interval counter loaded to INTERVAL-1.
- WAIT: counter decrements each cycle; at 0 -> REQ. en=0 -> IDLE.
- REQ: scrub_req=1; scrub_gnt=1 -> READ. en=0 -> IDLE (req dropped).
- READ (one cycle, gnt high): mem_A driven, mem_WE=0; at clock edge capture mem_RD, mem_s_err, mem_d_err. s_err -> WRITE, corr_cnt+1. d_err -> uncorr_cnt+1, last_err_addr=mem_A, then NEXT (or HALT, see Configuration). Clean -> NEXT. If scrub_gnt low during READ: no capture, return to REQ, same address.
- WRITE (one cycle): mem_WE=1, mem_WD=captured word, same mem_A -> NEXT. Arbiter must hold gnt while scrub_req high; scrub_req stays high through READ and WRITE, so no CPU access interleaves read and write-back.
- NEXT: scrub_req=0; word_idx+1, wrap DEPTH-1 -> 0 with pass_done pulse; -> WAIT (en=1) or IDLE (en=0).
- en falling mid-access: READ/WRITE complete; exit at NEXT.
- s_err and d_err both high: treated as d_err, no write-back.
- Counters saturate at all-ones; cleared only by rst.

## Timing
- Reset values: scrub_req=0, mem_WE=0, mem_A=0, mem_WD=0, corr_cnt=0, uncorr_cnt=0, last_err_addr=0, pass_done=0, halted=0; state IDLE, word_idx=0.
- All outputs registered or decoded from state register only; no combinational path from mem_* inputs to outputs.
- Clean word cost: INTERVAL (WAIT) + >=1 (REQ) + 1 (READ) + 1 (NEXT) cycles; corrected word adds 1 WRITE cycle.
- Full pass, no errors, gnt immediate: DEPTH*(INTERVAL+3) cycles.
- Reset asserted in any state forces IDLE immediately, dropping mem_WE mid-WRITE.

## Configuration
- SCRUB_DERR_HALT_EN defined: d_err in READ -> HALT; halted=1, scrub_req=0, word_idx frozen at failing word; leaves HALT only when en=0 (-> IDLE); resume rescans from the same word.
- Undefined: d_err logged and scrubbing continues; HALT state unreachable, halted tied 0.

## Structure
- Package scrub_pkg: state enum, CNT_W default, POISON_WORD=32'hBAAD_FEED (value memory returns on d_err, used by bench checks), word-to-byte address helper.
- One sub-module: sat_counter (parameterised width, inc, saturating), instantiated twice.

## Test plan
- Clean memory, DEPTH=8, INTERVAL=4, gnt tied 1 -> no WE pulses, pass_done every 8*7=56 cycles, counters 0.
- Flip bit 5 of word 3 -> exactly one WRITE at mem_A=0x0C with mem_WD=original data; stored codeword re-clean on next pass; corr_cnt=1.
- Flip two bits of word 6 (macro off) -> no write, uncorr_cnt=1, last_err_addr=0x18, scrubbing continues; macro on -> halted=1, word_idx stays 6 until en=0.
- gnt withheld 10 cycles in REQ, then dropped during READ -> scrub_req held, READ retried at same address, no counter change.
- rst pulse during WRITE -> mem_WE low asynchronously, all outputs at reset values, restart from word 0.
- Force corr_cnt to 0xFFFF (CNT_W=16) and inject another s_err -> stays 0xFFFF.
